// File: rtl/front_spi_slave.sv
// SPI mode-0 responder for the front-panel link: 24-bit MOSI frame in, 24-bit MISO word out, oversampled in i_clk.
// Optional interrupt output (o_irq / i_irq_clear) is enabled by defining FRONT_SPI_SLV_IRQ_EN.
module front_spi_slave #(
    parameter int                    DATA_WIDTH   = 24,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_spi_sclk,
    input  logic                  i_spi_cs_n,
    input  logic                  i_spi_mosi,
    output logic                  o_spi_miso,
    output logic                  o_miso_oe,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic                  o_rx_overrun,
    output logic                  o_frame_err,
`ifdef FRONT_SPI_SLV_IRQ_EN
    output logic                  o_irq,
    input  logic                  i_irq_clear,
`endif
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // sclk and cs_n keep one extra flop so the last two synchronised samples can be compared.
    logic [SYNC_STAGES:0]   sclk_sync_q;
    logic [SYNC_STAGES:0]   cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  rx_rise;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_sync_q[SYNC_STAGES] & ~cs_s;
    assign sclk_fall = ~sclk_s &  sclk_sync_q[SYNC_STAGES] & ~cs_s;
    assign cs_fall   = ~cs_s &  cs_sync_q[SYNC_STAGES];
    assign cs_rise   =  cs_s & ~cs_sync_q[SYNC_STAGES];

    // cs_n resets to the asserted level so a CS still held low after reset cannot look like a new falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
        end else begin
            // NOTE: sequential state always uses <= so every flop samples pre-edge values, independent of statement order.
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], i_spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], i_spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        bit_cnt_d   = bit_cnt_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_rise     = 1'b0;

        if (rx_valid_q && i_rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    tx_shift_d  = hold_full_q ? hold_q : TX_IDLE_WORD;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (sclk_fall) tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
            ST_DONE: begin
                if (bit_cnt_q == CNT_FULL) begin
                    // A consume in this same cycle frees the slot, so the new word wins over an overrun.
                    if (!rx_valid_q || i_rx_ready) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_rise    = ~rx_valid_q;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Ready implies empty, so this never collides with the frame-start unload above.
        if (i_tx_valid && !hold_full_q) begin
            hold_d      = i_tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            bit_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            bit_cnt_q   <= bit_cnt_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef FRONT_SPI_SLV_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q & ~i_irq_clear;
        if (rx_rise || overrun_d || frame_err_d) irq_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign o_irq = irq_q;
`endif

    always_comb begin
        o_busy       = (state_q == ST_SHIFT);
        o_miso_oe    = (state_q == ST_SHIFT);
        o_spi_miso   = (state_q == ST_SHIFT) & tx_shift_q[DATA_WIDTH-1];
        o_tx_ready   = ~hold_full_q;
        o_rx_data    = rx_data_q;
        o_rx_valid   = rx_valid_q;
        o_rx_overrun = overrun_q;
        o_frame_err  = frame_err_q;
    end

endmodule
